ysyx_22050133_seq_divider: RTL and testbench
============================================

Name: ysyx_22050133_seq_divider

Overview:
Iterative radix-2 restoring divider for the RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW instructions. It is the responder side of the EXU's div_valid/div_ready/out_valid handshake. It produces one quotient bit per cycle and holds its results until the next accepted operation. The EXU selects quotient or remainder and uses them without further sign extension.

Parameters:
XLEN, 64, operand/result width; word ops use XLEN/2.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  cancel operation in flight
div_valid  in  1  request valid; sampled with div_ready
divw  in  1  1 = 32-bit word op on operand bits [31:0]
div_signed  in  1  1 = signed (DIV/REM), 0 = unsigned
dividend  in  XLEN  dividend
divisor  in  XLEN  divisor
div_ready  out  1  can accept a request this cycle
out_valid  out  1  one-cycle pulse: quotient/remainder valid
quotient  out  XLEN  quotient, sign-extended from bit 31 when divw
remainder  out  XLEN  remainder, sign-extended from bit 31 when divw

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state IDLE, div_ready=1, out_valid=0, quotient=0, remainder=0, counter=0.
- Accept: div_valid && div_ready && !flush at an edge (call that cycle T). Operands, divw and div_signed are latched.
- Operand prep:
  - divw: use [31:0]; sign-extend when signed, zero-extend when unsigned.
  - signed: divide the absolute values; record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
- Iteration:
  - N = 64, or 32 when divw.
  - Each BUSY cycle: shift the {rem, dq} pair left by 1, trial-subtract the divisor, keep the result when it does not borrow, shift in the quotient bit.
  - The counter decrements from N-1; BUSY→DONE when the counter reaches 0.
  - Normal latency: BUSY during T+1..T+N, DONE and out_valid at T+N+1 (T+65 for 64-bit, T+33 for word).
- Result fix-up (computed when entering DONE):
  - negate the quotient if neg_q; negate the remainder if neg_r.
  - divw: sign-extend bit 31 of both results, for unsigned ops too.
- Special cases (RISC-V defined, no trap):
  - divisor==0: quotient = all ones; remainder = dividend (word op: sign-extended low 32 bits).
  - signed overflow (MIN / -1, where MIN is 64- or 32-bit per divw): quotient = MIN sign-extended, remainder = 0.
  - Without the optional feature, both still take the full N cycles; the final result is forced to the values above.
- div_ready:
  - 1 in IDLE and DONE, 0 in BUSY.
  - An accept in DONE goes straight to BUSY (back-to-back operation).
- DONE lasts one cycle (out_valid pulse), then IDLE unless a new request is accepted.
- quotient and remainder hold their value through IDLE until the next result is written.
- flush:
  - from any state → IDLE at the next edge, no out_valid, div_ready=1 in the following cycle.
  - flush overrides a simultaneous div_valid, which is not accepted.
  - result registers are left unchanged.
- rst mid-operation: same as the reset values above; it overrides flush and div_valid.
- Operand changes on input ports while BUSY have no effect.

Optional Feature:
YSYX_22050133_DIV_FASTPATH_EN
- Defined: divisor==0, signed overflow, and |dividend| < |divisor| (quotient 0, remainder = dividend) skip BUSY. DONE/out_valid at T+1.
- Undefined: every operation takes N+1 cycles.
- Results are bit-identical in both builds.

Decomposition:
- Shared defines header (existing ysyx_22050133 defines file):
  - state encodings YSYX_22050133_DIV_IDLE/BUSY/DONE
  - word-width constant
  - 64-bit and 32-bit MIN constants
- No sub-module. The abs/negate and sign-extend helpers are local functions; the datapath is a single sequential block plus combinational fix-up.

Test Plan:
- Unsigned 64-bit, 100 / 7 → quotient=14, remainder=2; out_valid exactly at T+65; div_ready=0 during T+1..T+64.
- Signed 64-bit, -7 / 2 → quotient=0xFFFFFFFFFFFFFFFD, remainder=0xFFFFFFFFFFFFFFFF. Unsigned 0x8000000000000000 / 3 → quotient=0x2AAAAAAAAAAAAAAA, remainder=2.
- DIVW, dividend 0x0000000180000000 / 0xFFFFFFFFFFFFFFFF → quotient=0xFFFFFFFF80000000, remainder=0; DIVUW 0xFFFFFFFE / 1 → quotient=0xFFFFFFFFFFFFFFFE; out_valid at T+33 (fast-path build: T+1 for the overflow case).
- Divide by zero: DIVU 0x1234 / 0 → quotient=0xFFFFFFFFFFFFFFFF, remainder=0x1234; REMUW 0x80000000 / 0 → remainder=0xFFFFFFFF80000000.
- flush at T+10 of a 64-bit op → no out_valid ever; div_ready=1 at T+11; next op 9/3 returns quotient=3, remainder=0. Repeat with rst instead of flush → all outputs at reset values.
- Back-to-back: div_valid held high with 20/6 then 21/4 → second accepted in the first op's DONE cycle; two out_valid pulses 65 cycles apart; results (3,2) then (5,1).

Source files
------------

// File: rtl/ysyx_22050133_seq_divider_pkg.sv
// Shared types and constants for the ysyx_22050133 sequential divider.
package ysyx_22050133_seq_divider_pkg;

  localparam int unsigned DIV_XLEN   = 64;
  localparam int unsigned DIV_WORD_W = DIV_XLEN / 2;

  localparam logic [DIV_XLEN-1:0] DIV_MIN_X = {1'b1, {(DIV_XLEN-1){1'b0}}};
  // Most negative word value, already sign-extended to DIV_XLEN.
  localparam logic [DIV_XLEN-1:0] DIV_MIN_W =
    {{(DIV_WORD_W+1){1'b1}}, {(DIV_WORD_W-1){1'b0}}};

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ysyx_22050133_seq_divider.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Optional build macro: YSYX_22050133_DIV_FASTPATH_EN lets divide-by-zero,
// signed overflow and |dividend| < |divisor| finish one cycle after accept.
module ysyx_22050133_seq_divider
  import ysyx_22050133_seq_divider_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                div_valid,
  input  logic                divw,
  input  logic                div_signed,
  input  logic [DIV_XLEN-1:0] dividend,
  input  logic [DIV_XLEN-1:0] divisor,
  output logic                div_ready,
  output logic                out_valid,
  output logic [DIV_XLEN-1:0] quotient,
  output logic [DIV_XLEN-1:0] remainder
);

  localparam int unsigned XLEN  = DIV_XLEN;
  localparam int unsigned HALF  = DIV_WORD_W;
  localparam int unsigned CNT_W = $clog2(XLEN);

  function automatic logic [XLEN-1:0] sext_w(input logic [HALF-1:0] x);
    return {{HALF{x[HALF-1]}}, x};
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] x);
    return neg ? ((~x) + XLEN'(1)) : x;
  endfunction

  // Sign fix-up, RISC-V special-case override and word sign extension.
  function automatic void fixup(input  logic [XLEN-1:0] q_mag,
                                input  logic [XLEN-1:0] r_mag,
                                input  logic [XLEN-1:0] a,
                                input  logic            neg_q,
                                input  logic            neg_r,
                                input  logic            dz,
                                input  logic            ovf,
                                input  logic            is_w,
                                output logic [XLEN-1:0] q,
                                output logic [XLEN-1:0] r);
    q = cond_neg(neg_q, q_mag);
    r = cond_neg(neg_r, r_mag);
    if (dz) begin
      q = '1;
      r = a;
    end else if (ovf) begin
      q = is_w ? DIV_MIN_W : DIV_MIN_X;
      r = '0;
    end
    if (is_w) begin
      q = sext_w(q[HALF-1:0]);
      r = sext_w(r[HALF-1:0]);
    end
  endfunction

  div_state_e      state_q, state_d;
  logic            ready_q, out_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] rem_q, dq_q, dvsr_q, a_q;
  logic [XLEN-1:0] quotient_q, remainder_q;
  logic            divw_q, negq_q, negr_q, dz_q, ovf_q;

  logic            accept_c, fast_c, last_c;
  logic [XLEN-1:0] a_ext_c, b_ext_c, abs_a_c, abs_b_c, dq_init_c;
  logic            neg_a_c, neg_b_c, dz_c, ovf_c;
  logic [XLEN:0]   sh_c;
  logic            ge_c;
  logic [XLEN-1:0] rem_n_c, dq_n_c, q_mag_c, res_q_c, res_r_c;

  assign accept_c = div_valid && (state_q != DIV_BUSY) && !flush;
  assign last_c   = (state_q == DIV_BUSY) && (cnt_q == '0);

  // Operand preparation: width select, sign extraction, magnitudes, special cases.
  always_comb begin
    a_ext_c = dividend;
    b_ext_c = divisor;
    if (divw) begin
      a_ext_c = div_signed ? sext_w(dividend[HALF-1:0]) : {{HALF{1'b0}}, dividend[HALF-1:0]};
      b_ext_c = div_signed ? sext_w(divisor[HALF-1:0])  : {{HALF{1'b0}}, divisor[HALF-1:0]};
    end
    neg_a_c   = div_signed & a_ext_c[XLEN-1];
    neg_b_c   = div_signed & b_ext_c[XLEN-1];
    abs_a_c   = cond_neg(neg_a_c, a_ext_c);
    abs_b_c   = cond_neg(neg_b_c, b_ext_c);
    dz_c      = (b_ext_c == '0);
    ovf_c     = div_signed && (a_ext_c == (divw ? DIV_MIN_W : DIV_MIN_X)) && (b_ext_c == '1);
    // Word ops start with the magnitude in the upper half so 32 shifts suffice.
    dq_init_c = divw ? {abs_a_c[HALF-1:0], {HALF{1'b0}}} : abs_a_c;
  end

  // One restoring iteration plus the final result from it.
  always_comb begin
    sh_c    = {rem_q, dq_q[XLEN-1]};
    ge_c    = (sh_c >= {1'b0, dvsr_q});
    rem_n_c = ge_c ? XLEN'(sh_c - {1'b0, dvsr_q}) : sh_c[XLEN-1:0];
    dq_n_c  = {dq_q[XLEN-2:0], ge_c};
    q_mag_c = divw_q ? {{HALF{1'b0}}, dq_n_c[HALF-1:0]} : dq_n_c;
    res_q_c = '0;
    res_r_c = '0;
    fixup(q_mag_c, rem_n_c, a_q, negq_q, negr_q, dz_q, ovf_q, divw_q, res_q_c, res_r_c);
  end

`ifdef YSYX_22050133_DIV_FASTPATH_EN
  logic [XLEN-1:0] fast_q_c, fast_r_c;

  assign fast_c = dz_c | ovf_c | (abs_a_c < abs_b_c);

  // Immediate result for the operations that skip iteration.
  always_comb begin
    fast_q_c = '0;
    fast_r_c = '0;
    fixup('0, abs_a_c, a_ext_c, neg_a_c ^ neg_b_c, neg_a_c, dz_c, ovf_c, divw,
          fast_q_c, fast_r_c);
  end
`else
  assign fast_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE, DIV_DONE: begin
        if (accept_c) state_d = fast_c ? DIV_DONE : DIV_BUSY;
        else          state_d = DIV_IDLE;
      end
      DIV_BUSY: if (cnt_q == '0) state_d = DIV_DONE;
      default:  state_d = DIV_IDLE;
    endcase
    if (flush) state_d = DIV_IDLE;
  end

  // Registered handshake outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      ready_q     <= (state_d != DIV_BUSY);
      out_valid_q <= (state_d == DIV_DONE);
    end
  end

  // Iteration datapath: load on accept, shift/subtract while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      dq_q   <= '0;
      dvsr_q <= '0;
      a_q    <= '0;
      divw_q <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept_c) begin
      cnt_q  <= divw ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
      rem_q  <= '0;
      dq_q   <= dq_init_c;
      dvsr_q <= abs_b_c;
      a_q    <= a_ext_c;
      divw_q <= divw;
      negq_q <= neg_a_c ^ neg_b_c;
      negr_q <= neg_a_c;
      dz_q   <= dz_c;
      ovf_q  <= ovf_c;
    end else if (state_q == DIV_BUSY) begin
      rem_q <= rem_n_c;
      dq_q  <= dq_n_c;
      if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Result registers: written only when a result is produced, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (!flush) begin
      if (last_c) begin
        quotient_q  <= res_q_c;
        remainder_q <= res_r_c;
      end
`ifdef YSYX_22050133_DIV_FASTPATH_EN
      else if (accept_c && fast_c) begin
        quotient_q  <= fast_q_c;
        remainder_q <= fast_r_c;
      end
`endif
    end
  end

  assign div_ready = ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_ysyx_22050133_seq_divider.sv
// Directed self-checking bench for ysyx_22050133_seq_divider.
module tb_ysyx_22050133_seq_divider;

  logic        clk = 1'b0;
  logic        rst, flush, div_valid, divw, div_signed;
  logic [63:0] dividend, divisor;
  logic        div_ready, out_valid;
  logic [63:0] quotient, remainder;

  int checks   = 0;
  int failures = 0;

  localparam int L64 = 65;
  localparam int L32 = 33;
`ifdef YSYX_22050133_DIV_FASTPATH_EN
  localparam int F64 = 1;
  localparam int F32 = 1;
`else
  localparam int F64 = 65;
  localparam int F32 = 33;
`endif

  always #5 clk = ~clk;

  ysyx_22050133_seq_divider dut (
    .clk(clk), .rst(rst), .flush(flush), .div_valid(div_valid), .divw(divw),
    .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
    .div_ready(div_ready), .out_valid(out_valid), .quotient(quotient),
    .remainder(remainder)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, scramble the inputs, and observe the result pulse.
  task automatic do_op(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b,
                       output int lat, output logic [63:0] q, output logic [63:0] r,
                       output int ready_hi);
    divw = w; div_signed = s; dividend = a; divisor = b; div_valid = 1'b1;
    step();
    div_valid = 1'b0; dividend = 64'hA5A5_5A5A_DEAD_BEEF; divisor = 64'h0;
    divw = ~w; div_signed = ~s;
    lat = -1; q = 'x; r = 'x; ready_hi = 0;
    for (int k = 1; k <= 200; k++) begin
      if (out_valid) begin
        lat = k; q = quotient; r = remainder;
        break;
      end
      if (div_ready) ready_hi++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; div_valid = 1'b0; divw = 1'b0; div_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", div_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (quotient !== 64'h0) begin failures++; $display("FAIL reset_q got=%h exp=0", quotient); end
    checks++; if (remainder !== 64'h0) begin failures++; $display("FAIL reset_r got=%h exp=0", remainder); end
  endtask

  task automatic test_unsigned();
    int lat, rh; logic [63:0] q, r;
    do_op(1'b0, 1'b0, 64'd100, 64'd7, lat, q, r, rh);
    checks++; if (lat != L64) begin failures++; $display("FAIL divu_lat got=%0d exp=%0d", lat, L64); end
    checks++; if (rh != 0) begin failures++; $display("FAIL divu_busy_ready got=%0d exp=0", rh); end
    checks++; if (q !== 64'd14) begin failures++; $display("FAIL divu_q got=%h exp=%h", q, 64'd14); end
    checks++; if (r !== 64'd2) begin failures++; $display("FAIL divu_r got=%h exp=%h", r, 64'd2); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL divu_pulse got=%b exp=0", out_valid); end
    checks++; if (quotient !== 64'd14) begin failures++; $display("FAIL divu_hold got=%h exp=%h", quotient, 64'd14); end
    do_op(1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd3, lat, q, r, rh);
    checks++; if (q !== 64'h2AAA_AAAA_AAAA_AAAA) begin failures++; $display("FAIL divu_big_q got=%h exp=2aaaaaaaaaaaaaaa", q); end
    checks++; if (r !== 64'd2) begin failures++; $display("FAIL divu_big_r got=%h exp=2", r); end
    do_op(1'b0, 1'b0, 64'd3, 64'd10, lat, q, r, rh);
    checks++; if (lat != F64) begin failures++; $display("FAIL small_lat got=%0d exp=%0d", lat, F64); end
    checks++; if (q !== 64'd0 || r !== 64'd3) begin failures++; $display("FAIL small_qr got=%h/%h exp=0/3", q, r); end
  endtask

  task automatic test_signed();
    int lat, rh; logic [63:0] q, r;
    do_op(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, q, r, rh);
    checks++; if (lat != L64) begin failures++; $display("FAIL div_lat got=%0d exp=%0d", lat, L64); end
    checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div_neg_q got=%h exp=fffffffffffffffd", q); end
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL div_neg_r got=%h exp=ffffffffffffffff", r); end
    do_op(1'b0, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, lat, q, r, rh);
    checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFD || r !== 64'd1) begin failures++; $display("FAIL div_negd got=%h/%h exp=fffffffffffffffd/1", q, r); end
    do_op(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, q, r, rh);
    checks++; if (lat != F64) begin failures++; $display("FAIL ovf64_lat got=%0d exp=%0d", lat, F64); end
    checks++; if (q !== 64'h8000_0000_0000_0000 || r !== 64'd0) begin failures++; $display("FAIL ovf64 got=%h/%h exp=8000000000000000/0", q, r); end
  endtask

  task automatic test_word();
    int lat, rh; logic [63:0] q, r;
    do_op(1'b1, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, q, r, rh);
    checks++; if (lat != F32) begin failures++; $display("FAIL divw_ovf_lat got=%0d exp=%0d", lat, F32); end
    checks++; if (q !== 64'hFFFF_FFFF_8000_0000 || r !== 64'd0) begin failures++; $display("FAIL divw_ovf got=%h/%h exp=ffffffff80000000/0", q, r); end
    do_op(1'b1, 1'b0, 64'h0000_0000_FFFF_FFFE, 64'd1, lat, q, r, rh);
    checks++; if (lat != L32) begin failures++; $display("FAIL divuw_lat got=%0d exp=%0d", lat, L32); end
    checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFE || r !== 64'd0) begin failures++; $display("FAIL divuw got=%h/%h exp=fffffffffffffffe/0", q, r); end
    do_op(1'b1, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002, lat, q, r, rh);
    checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFD || r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL divw_neg got=%h/%h exp=fffffffffffffffd/ffffffffffffffff", q, r); end
  endtask

  task automatic test_div_zero();
    int lat, rh; logic [63:0] q, r;
    do_op(1'b0, 1'b0, 64'h1234, 64'd0, lat, q, r, rh);
    checks++; if (lat != F64) begin failures++; $display("FAIL dz64_lat got=%0d exp=%0d", lat, F64); end
    checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF || r !== 64'h1234) begin failures++; $display("FAIL dz64 got=%h/%h exp=ffffffffffffffff/1234", q, r); end
    do_op(1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_0000_0000, lat, q, r, rh);
    checks++; if (lat != F32) begin failures++; $display("FAIL dz32_lat got=%0d exp=%0d", lat, F32); end
    checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF || r !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL dz32 got=%h/%h exp=ffffffffffffffff/ffffffff80000000", q, r); end
  endtask

  // Cancel a 64-bit op at T+10 via flush (use_rst=0) or rst (use_rst=1).
  task automatic test_abort(input bit use_rst);
    int lat, rh, pulses; logic [63:0] q, r, q_before, r_before;
    step();
    q_before = quotient; r_before = remainder;
    divw = 1'b0; div_signed = 1'b0; dividend = 64'd1000; divisor = 64'd7; div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    repeat (9) step();
    div_valid = 1'b1;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; div_valid = 1'b0;
    checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL abort%0d_ready got=%b exp=1", use_rst, div_ready); end
    checks++;
    if (quotient !== (use_rst ? 64'd0 : q_before) || remainder !== (use_rst ? 64'd0 : r_before)) begin
      failures++; $display("FAIL abort%0d_results got=%h/%h", use_rst, quotient, remainder);
    end
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      if (out_valid) pulses++;
      step();
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL abort%0d_no_valid got=%0d exp=0", use_rst, pulses); end
    do_op(1'b0, 1'b0, 64'd9, 64'd3, lat, q, r, rh);
    checks++; if (lat != L64 || q !== 64'd3 || r !== 64'd0) begin failures++; $display("FAIL abort%0d_next got lat=%0d %h/%h exp=65 3/0", use_rst, lat, q, r); end
  endtask

  task automatic test_back_to_back();
    int n, t0, t1; logic [63:0] q0, r0, q1, r1;
    step();
    n = 0; t0 = -1; t1 = -1; q0 = 'x; r0 = 'x; q1 = 'x; r1 = 'x;
    divw = 1'b0; div_signed = 1'b0; dividend = 64'd20; divisor = 64'd6; div_valid = 1'b1;
    step();
    dividend = 64'd21; divisor = 64'd4;
    for (int k = 1; k <= 200; k++) begin
      if (out_valid) begin
        if (n == 0) begin t0 = k; q0 = quotient; r0 = remainder; end
        else if (n == 1) begin t1 = k; q1 = quotient; r1 = remainder; end
        n++;
      end
      step();
      if (n >= 1) div_valid = 1'b0;
    end
    checks++; if (n != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", n); end
    checks++; if (t0 != L64 || t1 - t0 != 65) begin failures++; $display("FAIL b2b_timing got=%0d,%0d exp=65,130", t0, t1); end
    checks++; if (q0 !== 64'd3 || r0 !== 64'd2) begin failures++; $display("FAIL b2b_first got=%h/%h exp=3/2", q0, r0); end
    checks++; if (q1 !== 64'd5 || r1 !== 64'd1) begin failures++; $display("FAIL b2b_second got=%h/%h exp=5/1", q1, r1); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_word();
    test_div_zero();
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
